load_store_unit: RTL and testbench

Memory-stage initiator for the pipeline's word-wide data memory. It accepts one load or store request at a time over a valid/ready handshake and converts byte addresses into word addresses. It sign- or zero-extends byte and halfword loads, and performs byte and halfword stores as read-modify-write sequences. It sits between the EX/MEM pipeline register and the `memory` block, driving that block's `ce`/`wr_en`/`rd_en`/address/store-data pins.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 165 ++++++++++++++++
 tb/tb_load_store_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared widths, access-size and FSM state encodings, and the
//               request error decode used by the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

   localparam int LSU_DWIDTH     = 32;
   localparam int LSU_AWIDTH_MEM = 10;

   typedef enum logic [1:0] {
      SIZE_B   = 2'b00,
      SIZE_H   = 2'b01,
      SIZE_W   = 2'b10,
      SIZE_ILL = 2'b11
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_RESP  = 3'd4
   } lsu_state_e;

   // Illegal size, or an address not aligned to the access size.
   function automatic logic lsu_req_error(input logic [1:0] size, input logic [1:0] addr_lo);
      logic err;
      case (size)
         SIZE_B:  err = 1'b0;
         SIZE_H:  err = addr_lo[0];
         SIZE_W:  err = (addr_lo != 2'b00);
         default: err = 1'b1;
      endcase
      return err;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_lane_align
// Description : Little-endian lane handling. Extracts and sign/zero-extends
//               the addressed byte/half of a read word for loads, and merges
//               right-aligned store data into the addressed lane of a word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
   import lsu_pkg::*;
#(
   parameter int DWIDTH = LSU_DWIDTH
) (
   input  logic [1:0]        i_addr_lo,
   input  logic [1:0]        i_size,
   input  logic              i_unsigned,
   input  logic [DWIDTH-1:0] i_mem_word,
   input  logic [DWIDTH-1:0] i_store_data,
   output logic [DWIDTH-1:0] o_load_ext,
   output logic [DWIDTH-1:0] o_merged_word
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Select the addressed lane, then extend it (loads) or overwrite it (stores).
   always_comb begin
      w_byte        = i_mem_word[{i_addr_lo, 3'b000} +: 8];
      w_half        = i_mem_word[{i_addr_lo[1], 4'b0000} +: 16];
      o_load_ext    = i_mem_word;
      o_merged_word = i_mem_word;
      case (i_size)
         SIZE_B: begin
            o_load_ext = {{(DWIDTH-8){~i_unsigned & w_byte[7]}}, w_byte};
            o_merged_word[{i_addr_lo, 3'b000} +: 8] = i_store_data[7:0];
         end
         SIZE_H: begin
            o_load_ext = {{(DWIDTH-16){~i_unsigned & w_half[15]}}, w_half};
            o_merged_word[{i_addr_lo[1], 4'b0000} +: 16] = i_store_data[15:0];
         end
         default: begin
            o_load_ext    = i_mem_word;
            o_merged_word = i_store_data;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-stage initiator for the word-wide data memory. One
//               request at a time; byte/half loads are extracted and
//               extended, byte/half stores are done as read-modify-write.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int DWIDTH     = LSU_DWIDTH,
   parameter int AWIDTH_MEM = LSU_AWIDTH_MEM
) (
   input  logic                  lsu_clk,
   input  logic                  lsu_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [AWIDTH_MEM+1:0] req_addr,
   input  logic [DWIDTH-1:0]     req_wdata,
   output logic                  rsp_valid,
   output logic [DWIDTH-1:0]     rsp_rdata,
   output logic                  rsp_err,
   output logic                  mem_ce,
   output logic                  mem_wr_en,
   output logic                  mem_rd_en,
   output logic [AWIDTH_MEM-1:0] mem_addr,
   output logic [DWIDTH-1:0]     mem_store_data,
   input  logic [DWIDTH-1:0]     mem_load_data
);

   lsu_state_e              r_state;
   lsu_state_e              w_state_nxt;
   logic                    r_we;
   logic [1:0]              r_size;
   logic                    r_unsigned;
   logic [AWIDTH_MEM+1:0]   r_addr;
   logic [DWIDTH-1:0]       r_wdata;
   logic [DWIDTH-1:0]       r_merged;
   logic [DWIDTH-1:0]       r_rdata;
   logic                    r_err;
   logic                    w_req_err;
   logic                    w_accept;
   logic [DWIDTH-1:0]       w_load_ext;
   logic [DWIDTH-1:0]       w_merged;

   assign w_req_err = lsu_req_error(req_size, req_addr[1:0]);
   assign w_accept  = req_valid && req_ready;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   lsu_lane_align #(
      .DWIDTH(DWIDTH)
   ) u_lane_align (
      .i_addr_lo     (r_addr[1:0]),
      .i_size        (r_size),
      .i_unsigned    (r_unsigned),
      .i_mem_word    (mem_load_data),
      .i_store_data  (r_wdata),
      .o_load_ext    (w_load_ext),
      .o_merged_word (w_merged)
   );

   // State register; reset abandons any operation in flight.
   always_ff @(posedge lsu_clk) begin
      if (!lsu_rst) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Request latch and response data; response fields change only on RESP entry.
   always_ff @(posedge lsu_clk) begin
      if (!lsu_rst) begin
         r_we       <= 1'b0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_merged   <= '0;
         r_rdata    <= '0;
         r_err      <= 1'b0;
      end else begin
         if (w_accept) begin
            r_we       <= req_we;
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_addr     <= req_addr;
            r_wdata    <= req_wdata;
            if (w_req_err) begin
               r_rdata <= '0;
               r_err   <= 1'b1;
            end
         end
         if (r_state == ST_WAIT) begin
            if (r_we) begin
               r_merged <= w_merged;
            end else begin
               r_rdata <= w_load_ext;
               r_err   <= 1'b0;
            end
         end
         if (r_state == ST_WRITE) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
         end
      end
   end

   // Next-state and state-decoded outputs; everything forced low during reset.
   always_comb begin
      w_state_nxt    = r_state;
      req_ready      = 1'b0;
      rsp_valid      = 1'b0;
      mem_ce         = 1'b0;
      mem_wr_en      = 1'b0;
      mem_rd_en      = 1'b0;
      mem_addr       = '0;
      mem_store_data = '0;
      case (r_state)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (w_req_err)                          w_state_nxt = ST_RESP;
               else if (req_we && (req_size == SIZE_W)) w_state_nxt = ST_WRITE;
               else                                     w_state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            mem_ce      = 1'b1;
            mem_rd_en   = 1'b1;
            mem_addr    = r_addr[AWIDTH_MEM+1:2];
            w_state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            mem_addr    = r_addr[AWIDTH_MEM+1:2];
            w_state_nxt = r_we ? ST_WRITE : ST_RESP;
         end
         ST_WRITE: begin
            mem_ce         = 1'b1;
            mem_wr_en      = 1'b1;
            mem_addr       = r_addr[AWIDTH_MEM+1:2];
            mem_store_data = (r_size == SIZE_W) ? r_wdata : r_merged;
            w_state_nxt    = ST_RESP;
         end
         ST_RESP: begin
            rsp_valid   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (!lsu_rst) begin
         req_ready      = 1'b0;
         rsp_valid      = 1'b0;
         mem_ce         = 1'b0;
         mem_wr_en      = 1'b0;
         mem_rd_en      = 1'b0;
         mem_addr       = '0;
         mem_store_data = '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Scoreboard bench for load_store_unit with a registered-read
//               word memory model attached to the memory pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   logic        lsu_clk = 1'b0;
   logic        lsu_rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [11:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        mem_ce;
   logic        mem_wr_en;
   logic        mem_rd_en;
   logic [9:0]  mem_addr;
   logic [31:0] mem_store_data;
   logic [31:0] mem_load_data;

   logic [31:0] mem [0:1023];

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          lat;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   last_acc = 0;
   int   acc_cnt  = 0;
   int   ce_cnt   = 0;
   int   wr_cnt   = 0;
   logic [9:0] last_wr_addr = '0;
   bit   busy     = 1'b0;

   always #5 lsu_clk = ~lsu_clk;

   load_store_unit #(
      .DWIDTH(32),
      .AWIDTH_MEM(10)
   ) dut (
      .lsu_clk        (lsu_clk),
      .lsu_rst        (lsu_rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_we         (req_we),
      .req_size       (req_size),
      .req_unsigned   (req_unsigned),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .rsp_valid      (rsp_valid),
      .rsp_rdata      (rsp_rdata),
      .rsp_err        (rsp_err),
      .mem_ce         (mem_ce),
      .mem_wr_en      (mem_wr_en),
      .mem_rd_en      (mem_rd_en),
      .mem_addr       (mem_addr),
      .mem_store_data (mem_store_data),
      .mem_load_data  (mem_load_data)
   );

   // Word memory: synchronous write, registered read.
   always @(posedge lsu_clk) begin
      if (mem_ce && mem_wr_en) mem[mem_addr] <= mem_store_data;
      if (mem_ce && mem_rd_en) mem_load_data <= mem[mem_addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: strobe counting, busy-window ready check, scoreboard compare.
   always @(negedge lsu_clk) begin : monitor
      exp_t e;
      cyc++;
      if (!lsu_rst) busy = 1'b0;
      if (mem_ce) ce_cnt++;
      if (mem_wr_en) begin
         wr_cnt++;
         last_wr_addr = mem_addr;
      end
      if (busy) check("ready_low_while_busy", {31'b0, req_ready}, 32'd0);
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got rsp_valid=1 expected none");
         end else begin
            e = sb.pop_front();
            check({e.name, "_err"}, {31'b0, rsp_err}, {31'b0, e.err});
            check({e.name, "_rdata"}, rsp_rdata, e.rdata);
            check({e.name, "_latency"}, cyc - last_acc, e.lat);
         end
         busy = 1'b0;
      end
      if (req_valid && req_ready) begin
         last_acc = cyc;
         acc_cnt++;
         busy = 1'b1;
      end
   end

   // Issue one request; lat < 0 means no response is expected.
   task automatic send(input string name, input logic we, input logic [1:0] size,
                       input logic uns, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic exp_err, input logic [31:0] exp_rdata, input int lat,
                       input bit keep);
      int guard = 0;
      while (!req_ready && guard < 50) begin
         @(posedge lsu_clk); #1;
         guard++;
      end
      if (!req_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_ready_timeout: got req_ready=0 expected 1", name);
      end
      req_valid    = 1'b1;
      req_we       = we;
      req_size     = size;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wdata;
      if (lat >= 0) sb.push_back('{exp_err, exp_rdata, lat, name});
      @(posedge lsu_clk); #1;
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int guard = 0;
      while ((sb.size() != 0 || busy) && guard < 40) begin
         @(posedge lsu_clk); #1;
         guard++;
      end
      check({name, "_drained"}, sb.size(), 32'd0);
   endtask

   initial begin
      int wr0;
      int ce0;
      int acc0;
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      lsu_rst      = 1'b0;
      req_valid    = 1'b0;
      req_we       = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (3) @(posedge lsu_clk);
      #1;
      check("rst_ready",  {31'b0, req_ready}, 32'd0);
      check("rst_valid",  {31'b0, rsp_valid}, 32'd0);
      check("rst_rdata",  rsp_rdata, 32'd0);
      check("rst_err",    {31'b0, rsp_err}, 32'd0);
      check("rst_strobe", {29'b0, mem_ce, mem_wr_en, mem_rd_en}, 32'd0);
      check("rst_addr",   {22'b0, mem_addr}, 32'd0);
      check("rst_sdata",  mem_store_data, 32'd0);
      lsu_rst = 1'b1;
      @(posedge lsu_clk); #1;
      check("idle_ready", {31'b0, req_ready}, 32'd1);

      // Word store then word load.
      wr0 = wr_cnt;
      send("sw_10", 1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b0, 32'h0, 2, 1'b0);
      drain("sw_10");
      check("sw_wr_pulses", wr_cnt - wr0, 32'd1);
      check("sw_wr_addr", {22'b0, last_wr_addr}, 32'd4);
      check("sw_mem4", mem[4], 32'hDEADBEEF);
      send("lw_10", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'hDEADBEEF, 3, 1'b0);
      drain("lw_10");

      // Byte store / loads.
      send("sb_11", 1'b1, 2'b00, 1'b0, 12'h011, 32'h123456AA, 1'b0, 32'h0, 4, 1'b0);
      drain("sb_11");
      check("sb_mem4", mem[4], 32'hDEADAAEF);
      send("lb_11", 1'b0, 2'b00, 1'b0, 12'h011, 32'h0, 1'b0, 32'hFFFFFFAA, 3, 1'b0);
      send("lbu_11", 1'b0, 2'b00, 1'b1, 12'h011, 32'h0, 1'b0, 32'h000000AA, 3, 1'b0);
      drain("lb");

      // Half load / store.
      send("lh_12", 1'b0, 2'b01, 1'b0, 12'h012, 32'h0, 1'b0, 32'hFFFFDEAD, 3, 1'b0);
      send("sh_12", 1'b1, 2'b01, 1'b0, 12'h012, 32'hFFFF1234, 1'b0, 32'h0, 4, 1'b0);
      send("lw_after_sh", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'h1234AAEF, 3, 1'b0);
      drain("half");

      // Misaligned and illegal requests.
      ce0 = ce_cnt;
      send("lh_13_err", 1'b0, 2'b01, 1'b0, 12'h013, 32'h0, 1'b1, 32'h0, 1, 1'b0);
      send("sw_16_err", 1'b1, 2'b10, 1'b0, 12'h016, 32'h55667788, 1'b1, 32'h0, 1, 1'b0);
      send("ill_size_err", 1'b0, 2'b11, 1'b0, 12'h010, 32'h0, 1'b1, 32'h0, 1, 1'b0);
      drain("err");
      check("err_no_ce", ce_cnt - ce0, 32'd0);
      check("err_mem5", mem[5], 32'h0);
      check("err_mem4", mem[4], 32'h1234AAEF);

      // Back-to-back word loads with req_valid held.
      send("sw_00", 1'b1, 2'b10, 1'b0, 12'h000, 32'h0BADF00D, 1'b0, 32'h0, 2, 1'b0);
      send("sw_14", 1'b1, 2'b10, 1'b0, 12'h014, 32'hCAFEF00D, 1'b0, 32'h0, 2, 1'b0);
      drain("preload");
      acc0 = acc_cnt;
      send("b2b_lw_10", 1'b0, 2'b10, 1'b0, 12'h010, 32'h0, 1'b0, 32'h1234AAEF, 3, 1'b1);
      send("b2b_lw_00", 1'b0, 2'b10, 1'b0, 12'h000, 32'h0, 1'b0, 32'h0BADF00D, 3, 1'b1);
      send("b2b_lw_14", 1'b0, 2'b10, 1'b0, 12'h014, 32'h0, 1'b0, 32'hCAFEF00D, 3, 1'b0);
      drain("b2b");
      check("b2b_accepts", acc_cnt - acc0, 32'd3);

      // Reset during WAIT of a byte store.
      wr0 = wr_cnt;
      send("sb_rst", 1'b1, 2'b00, 1'b0, 12'h010, 32'h00000055, 1'b0, 32'h0, -1, 1'b0);
      @(posedge lsu_clk); #1;
      check("rst_wait_addr", {22'b0, mem_addr}, 32'd4);
      lsu_rst = 1'b0;
      @(posedge lsu_clk); #1;
      check("rsth_ready",  {31'b0, req_ready}, 32'd0);
      check("rsth_strobe", {29'b0, mem_ce, mem_wr_en, mem_rd_en}, 32'd0);
      check("rsth_rsp",    {30'b0, rsp_valid, rsp_err}, 32'd0);
      check("rsth_rdata",  rsp_rdata, 32'd0);
      lsu_rst = 1'b1;
      @(posedge lsu_clk); #1;
      check("rstx_ready",  {31'b0, req_ready}, 32'd1);
      check("rstx_addr",   {22'b0, mem_addr}, 32'd0);
      check("rstx_sdata",  mem_store_data, 32'd0);
      repeat (6) @(posedge lsu_clk);
      #1;
      check("rst_no_write", wr_cnt - wr0, 32'd0);
      check("rst_mem4", mem[4], 32'h1234AAEF);
      drain("final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
